// File: rtl/program_sequencer.sv
// Program sequencer: walks instruction memory one word at a time through
// FETCH / DECODE / EXECUTE, drives register-file indices and write strobe,
// and stops on halt, illegal opcode or running past the last address.
module program_sequencer #(
    parameter logic [7:0] ADDR_LAST = 8'd127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  programSelectIn,
    output logic [7:0]  programSelect,
    output logic [7:0]  address,
    input  logic [15:0] instruction,
    output logic [3:0]  regDest,
    output logic [3:0]  regSrcA,
    output logic [3:0]  regSrcB,
    output logic [7:0]  immediate,
    output logic        useImmediate,
    output logic [3:0]  aluOp,
    output logic        regWrite,
    output logic        busy,
    output logic        halted,
    output logic        illegalOp,
    output logic        overrun,
    output logic [7:0]  instrCount
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        HALTED
    } stateType;

    stateType    state;
    stateType    nextState;
    logic [15:0] instrReg;
    logic [3:0]  opcode;
    logic        opLegal;
    logic        opHalt;
    logic        startAccept;
    logic        atLast;
    logic [7:0]  countNext;

    assign opcode      = instrReg[15:12];
    assign opHalt      = (opcode == 4'hE);
    assign atLast      = (address == ADDR_LAST);
    assign startAccept = start && (programSelectIn != 8'h00)
                         && ((state == IDLE) || (state == HALTED));
    assign countNext   = (instrCount == 8'hFF) ? instrCount : instrCount + 8'd1;
    assign busy        = (state == FETCH) || (state == DECODE) || (state == EXECUTE);
    assign halted      = (state == HALTED);

    // Classify the held instruction's opcode as one the ALU understands.
    always_comb begin
        opLegal = 1'b0;
        case (opcode)
            4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB, 4'hE: opLegal = 1'b1;
            default: opLegal = 1'b0;
        endcase
    end

    // State register; reset drops straight back to IDLE even mid-instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: three cycles per instruction, any stop condition parks in HALTED.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, HALTED: begin
                if (startAccept) begin
                    nextState = FETCH;
                end
            end
            FETCH:   nextState = DECODE;
            DECODE:  nextState = EXECUTE;
            EXECUTE: begin
                if (opHalt || !opLegal || atLast) begin
                    nextState = HALTED;
                end else begin
                    nextState = FETCH;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath registers: capture, decode and retire; regWrite is a one-cycle registered strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            programSelect <= 8'h00;
            address       <= 8'h00;
            instrReg      <= 16'h0000;
            regDest       <= 4'h0;
            regSrcA       <= 4'h0;
            regSrcB       <= 4'h0;
            immediate     <= 8'h00;
            useImmediate  <= 1'b0;
            aluOp         <= 4'h0;
            regWrite      <= 1'b0;
            illegalOp     <= 1'b0;
            overrun       <= 1'b0;
            instrCount    <= 8'h00;
        end else begin
            regWrite <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (startAccept) begin
                        programSelect <= programSelectIn;
                        address       <= 8'h00;
                        instrCount    <= 8'h00;
                        illegalOp     <= 1'b0;
                        overrun       <= 1'b0;
                    end
                end
                FETCH: begin
                    instrReg <= instruction;
                end
                DECODE: begin
                    regDest      <= instrReg[11:8];
                    regSrcA      <= instrReg[7:4];
                    regSrcB      <= instrReg[3:0];
                    immediate    <= instrReg[7:0];
                    aluOp        <= opcode;
                    useImmediate <= (opcode == 4'h0);
                    regWrite     <= opLegal && !opHalt;
                end
                EXECUTE: begin
                    if (opHalt) begin
                        instrCount <= countNext;
                    end else if (!opLegal) begin
                        illegalOp <= 1'b1;
                    end else begin
                        instrCount <= countNext;
                        if (atLast) begin
                            overrun <= 1'b1;
                        end else begin
                            address <= address + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed programs plus random
// programs, each compared cycle by cycle against a program-level model.
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  programSelectIn;
    logic [7:0]  programSelect;
    logic [7:0]  address;
    logic [15:0] instruction;
    logic [3:0]  regDest;
    logic [3:0]  regSrcA;
    logic [3:0]  regSrcB;
    logic [7:0]  immediate;
    logic        useImmediate;
    logic [3:0]  aluOp;
    logic        regWrite;
    logic        busy;
    logic        halted;
    logic        illegalOp;
    logic        overrun;
    logic [7:0]  instrCount;

    logic [15:0] mem [0:255];
    int          checks = 0;
    int          failures = 0;

    localparam logic [15:0] LEGAL_MASK = 16'b0100_1001_1111_0101;
    localparam int          LAST_ADDR  = 127;

    program_sequencer #(.ADDR_LAST(8'd127)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .programSelectIn(programSelectIn),
        .programSelect(programSelect),
        .address(address),
        .instruction(instruction),
        .regDest(regDest),
        .regSrcA(regSrcA),
        .regSrcB(regSrcB),
        .immediate(immediate),
        .useImmediate(useImmediate),
        .aluOp(aluOp),
        .regWrite(regWrite),
        .busy(busy),
        .halted(halted),
        .illegalOp(illegalOp),
        .overrun(overrun),
        .instrCount(instrCount)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Combinational instruction memory.
    always_comb instruction = mem[address];

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".halted"}, halted, 0);
        checkOutput({tag, ".address"}, address, 0);
        checkOutput({tag, ".programSelect"}, programSelect, 0);
        checkOutput({tag, ".regDest"}, regDest, 0);
        checkOutput({tag, ".regSrcA"}, regSrcA, 0);
        checkOutput({tag, ".regSrcB"}, regSrcB, 0);
        checkOutput({tag, ".immediate"}, immediate, 0);
        checkOutput({tag, ".useImmediate"}, useImmediate, 0);
        checkOutput({tag, ".aluOp"}, aluOp, 0);
        checkOutput({tag, ".regWrite"}, regWrite, 0);
        checkOutput({tag, ".illegalOp"}, illegalOp, 0);
        checkOutput({tag, ".overrun"}, overrun, 0);
        checkOutput({tag, ".instrCount"}, instrCount, 0);
    endtask

    // Presents a start pulse that is sampled on exactly one rising edge; call at a negedge.
    task automatic applyStimulus(input logic [7:0] sel);
        programSelectIn = sel;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clearMem();
        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    endtask

    // Runs the program in mem from address 0 and checks every cycle against the model.
    task automatic runProgram(input string name, input logic [7:0] sel, input bit poke);
        int   nInstr;
        int   expCount;
        bit   expIllegal;
        bit   expOverrun;
        int   expAddr;
        bit   isWrite [0:255];
        int   i;
        int   ph;
        logic [3:0] op;

        nInstr = 0;
        expCount = 0;
        expIllegal = 0;
        expOverrun = 0;
        expAddr = 0;
        for (int pc = 0; pc < 256; pc++) begin
            op = mem[pc][15:12];
            nInstr++;
            expAddr = pc;
            isWrite[pc] = LEGAL_MASK[op] && (op != 4'hE);
            if (op == 4'hE) begin
                expCount++;
                break;
            end
            if (!LEGAL_MASK[op]) begin
                expIllegal = 1;
                break;
            end
            expCount++;
            if (pc == LAST_ADDR) begin
                expOverrun = 1;
                break;
            end
        end

        @(negedge clk);
        applyStimulus(sel);
        for (int cyc = 1; cyc <= 3 * nInstr + 1; cyc++) begin
            @(negedge clk);
            if (poke && cyc == 2) begin
                programSelectIn = 8'h08;
                start = 1'b1;
            end
            if (poke && cyc == 4) start = 1'b0;
            if (cyc <= 3 * nInstr) begin
                i  = (cyc - 1) / 3;
                ph = (cyc - 1) % 3;
                checkOutput({name, ".busy"}, busy, 1);
                checkOutput({name, ".halted"}, halted, 0);
                checkOutput({name, ".address"}, address, 16'(i));
                checkOutput({name, ".instrCount"}, instrCount, 16'(i));
                checkOutput({name, ".illegalOp"}, illegalOp, 0);
                checkOutput({name, ".overrun"}, overrun, 0);
                checkOutput({name, ".programSelect"}, programSelect, sel);
                checkOutput({name, ".regWrite"}, regWrite, (ph == 2) && isWrite[i]);
                if (ph == 2) begin
                    checkOutput({name, ".regDest"}, regDest, mem[i][11:8]);
                    checkOutput({name, ".regSrcA"}, regSrcA, mem[i][7:4]);
                    checkOutput({name, ".regSrcB"}, regSrcB, mem[i][3:0]);
                    checkOutput({name, ".immediate"}, immediate, mem[i][7:0]);
                    checkOutput({name, ".aluOp"}, aluOp, mem[i][15:12]);
                    checkOutput({name, ".useImmediate"}, useImmediate, mem[i][15:12] == 4'h0);
                end
            end else begin
                checkOutput({name, ".end.busy"}, busy, 0);
                checkOutput({name, ".end.halted"}, halted, 1);
                checkOutput({name, ".end.regWrite"}, regWrite, 0);
                checkOutput({name, ".end.address"}, address, 16'(expAddr));
                checkOutput({name, ".end.instrCount"}, instrCount, 16'(expCount));
                checkOutput({name, ".end.illegalOp"}, illegalOp, 16'(expIllegal));
                checkOutput({name, ".end.overrun"}, overrun, 16'(expOverrun));
                checkOutput({name, ".end.programSelect"}, programSelect, sel);
            end
        end
        // Held in HALTED with no start.
        @(negedge clk);
        checkOutput({name, ".hold.halted"}, halted, 1);
        checkOutput({name, ".hold.address"}, address, 16'(expAddr));
        checkOutput({name, ".hold.regWrite"}, regWrite, 0);
    endtask

    logic [3:0] nonHaltOps [0:7];
    logic [3:0] illegalOps [0:6];

    initial begin
        int   len;
        logic [7:0] sel;

        nonHaltOps = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB};
        illegalOps = '{4'h1, 4'h3, 4'h9, 4'hA, 4'hC, 4'hD, 4'hF};
        clearMem();
        rst_n = 1'b0;
        start = 1'b0;
        programSelectIn = 8'h00;
        #2;
        checkAllClear("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAllClear("postReset");

        // Six-word program ending in halt.
        clearMem();
        mem[0] = 16'h0102; mem[1] = 16'h2F10; mem[2] = 16'h0203;
        mem[3] = 16'h2F20; mem[4] = 16'h4F21; mem[5] = 16'hE000;
        runProgram("prog6", 8'h04, 0);

        // Immediate load.
        clearMem();
        mem[0] = 16'h0105; mem[1] = 16'hE000;
        runProgram("setImm", 8'h31, 0);

        // Illegal opcode at address 2 with a start poked while busy.
        clearMem();
        mem[0] = 16'h0011; mem[1] = 16'h5123; mem[2] = 16'h3456;
        runProgram("illegal", 8'h04, 1);

        // Restart from HALTED with a new select clears the flags.
        clearMem();
        mem[0] = 16'h2345; mem[1] = 16'hB9A1; mem[2] = 16'hE123;
        runProgram("restart", 8'h08, 0);

        // Run off the end of memory.
        clearMem();
        runProgram("overrun", 8'h10, 0);

        // Reset mid-DECODE, then a zero-select start is ignored.
        clearMem();
        mem[0] = 16'h7ABC; mem[1] = 16'hE000;
        @(negedge clk);
        applyStimulus(8'h04);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midReset.preBusy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkAllClear("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAllClear("midReset.release");
        applyStimulus(8'h00);
        @(negedge clk);
        checkOutput("zeroSel.busy", busy, 0);
        checkOutput("zeroSel.programSelect", programSelect, 0);
        @(negedge clk);
        checkOutput("zeroSel.busy2", busy, 0);

        // Random programs.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
            len = $urandom_range(1, 25);
            for (int k = 0; k < len - 1; k++)
                mem[k] = {nonHaltOps[$urandom_range(0, 7)], 12'($urandom)};
            if ($urandom_range(0, 1) == 1)
                mem[len - 1] = {4'hE, 12'($urandom)};
            else
                mem[len - 1] = {illegalOps[$urandom_range(0, 6)], 12'($urandom)};
            sel = 8'($urandom_range(1, 255));
            runProgram($sformatf("rand%0d", r), sel, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter ADDR_LAST, default 8'd127, meaning the last valid instruction address; no further parameters.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request to run the selected program; sampled each clk.
REQ-005 SHALL have port programSelectIn  in  8  program switch bits; captured on an accepted start.
REQ-006 SHALL have port programSelect  out  8  latched select driven to instruction memory.
REQ-007 SHALL have port address  out  8  program counter driven to instruction memory.
REQ-008 SHALL have port instruction  in  16  combinational instruction memory read data.
REQ-009 SHALL have ports regDest, regSrcA, regSrcB  out  4 each  register file write and read indices.
REQ-010 SHALL have ports immediate  out  8 and useImmediate  out  1  constant operand and its select.
REQ-011 SHALL have ports aluOp  out  4  (equals opcode) and regWrite  out  1  (register file write strobe).
REQ-012 SHALL have ports busy, halted, illegalOp, overrun  out  1 each  status flags.
REQ-013 SHALL have port instrCount  out  8  retired instruction count; saturates at 255.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, HALTED.
REQ-015 IDLE: start=1 with programSelectIn!=0 SHALL latch programSelect, clear address, instrCount and all flags, then go to FETCH.
REQ-016 start with programSelectIn==0 SHALL be ignored; start in FETCH/DECODE/EXECUTE SHALL be ignored.
REQ-017 FETCH: the instruction register SHALL capture instruction at the end of the cycle; next state DECODE.
REQ-018 DECODE: outputs SHALL be set from the instruction register: regDest=[11:8], regSrcA=[7:4], regSrcB=[3:0], aluOp=[15:12], immediate=[7:0], useImmediate=1 only for opcode 0000.
REQ-019 Legal opcodes SHALL be 0000 set, 0010 copy, 0100 add, 0101 neg, 0110 and, 0111 or, 1000 shl, 1011 gt, and 1110 halt.
REQ-020 EXECUTE, for any legal opcode except halt: regWrite SHALL be 1 for exactly this cycle, instrCount SHALL increment and address SHALL increment; next state FETCH.
REQ-021 Each non-halt instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXECUTE).
REQ-022 Halt in EXECUTE: no regWrite, address held, instrCount incremented; next state HALTED, halted=1.
REQ-023 Illegal opcode in EXECUTE: no regWrite, illegalOp=1 (sticky), address held; next state HALTED.
REQ-024 EXECUTE at address==ADDR_LAST with a non-halt legal opcode: write performed, overrun=1, address held at ADDR_LAST; next state HALTED.
REQ-025 HALTED: all outputs held and regWrite=0; an accepted start SHALL restart as from IDLE (REQ-015).
REQ-026 busy SHALL be 1 in FETCH, DECODE and EXECUTE, and 0 in IDLE and HALTED.
REQ-027 Decoded outputs SHALL hold their values between DECODE cycles; regWrite SHALL be a registered output, glitch-free.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, address=0, programSelect=0, all decode outputs 0, regWrite=0, busy=0, all flags 0 and instrCount=0, including mid-instruction.
REQ-029 No register write SHALL occur in the first cycle after rst_n deasserts.

Verification
REQ-030 programSelectIn=8'h04, start pulse, with memory returning 0x0102, 0x2F10, 0x0203, 0x2F20, 0x4F21, 0xE000 -> exactly 5 regWrite pulses, 3 cycles apart; halted=1 at address 5; instrCount=6.
REQ-031 Memory word 0x0105 -> in EXECUTE: regDest=1, useImmediate=1, immediate=8'h05, aluOp=0, regWrite=1.
REQ-032 Opcode 0x3xxx at address 2 -> illegalOp=1, halted state, address=2, no regWrite in that EXECUTE cycle.
REQ-033 All memory words 0x0000 -> 128 regWrite pulses, overrun=1, address=127, instrCount=128.
REQ-034 rst_n pulled low during DECODE, then released -> IDLE with all outputs 0; a second start with programSelectIn=8'h00 leaves busy=0.
REQ-035 start asserted while busy, then in HALTED with programSelectIn=8'h08 -> ignored while busy; restart from HALTED gives address=0, programSelect=8'h08 and flags cleared.
